// File: rtl/id_stage_pipe_pkg.sv
// Shared constants for the ID stage: major opcodes, funct fields and ALU codes.
package id_stage_pipe_pkg;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ADD is deliberately zero so a cleared entry reads as "no operation".
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Register-register ALU operation for the base funct7 encoding.
    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        case (funct3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_pipe_decode.sv
// Combinational decoder: turns one instruction word plus register data into
// the fields of the next ID/EX entry. Illegal encodings come out fully zeroed.
module id_stage_pipe_decode
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int RADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH = 4
) (
    input  logic [31:0]            inst,
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        reg1_rdata,
    input  logic [XLEN-1:0]        reg2_rdata,
    output logic [RADDR_WIDTH-1:0] reg1_raddr,
    output logic [RADDR_WIDTH-1:0] reg2_raddr,
    output logic                   reg1_re,
    output logic                   reg2_re,
    output logic [XLEN-1:0]        op1,
    output logic [XLEN-1:0]        op2,
    output logic [ALUOP_WIDTH-1:0] alu_op,
    output logic                   word,
    output logic                   reg_we,
    output logic [RADDR_WIDTH-1:0] reg_waddr,
    output logic                   illegal
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    // Immediates are formed at 64 bits and truncated so one expression serves both widths.
    logic [63:0] imm_i64;
    logic [63:0] imm_u64;
    logic [63:0] shamt64;
    logic [63:0] shamt32;
    logic        shift_hi_zero;
    logic        shift_hi_sra;

    assign imm_i64 = {{52{inst[31]}}, inst[31:20]};
    assign imm_u64 = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign shamt32 = {59'b0, inst[24:20]};
    assign shamt64 = IS_RV64 ? {58'b0, inst[25:20]} : shamt32;

    // On RV64 bit 25 belongs to the shift amount, so only bits 31:26 qualify the shift.
    assign shift_hi_zero = IS_RV64 ? (inst[31:26] == 6'b000000) : (funct7 == F7_BASE);
    assign shift_hi_sra  = IS_RV64 ? (inst[31:26] == 6'b010000) : (funct7 == F7_ALT);

    logic    legal;
    logic    re1;
    logic    re2;
    alu_op_e alu;

    // Opcode/funct decode; any path that does not set legal leaves the entry illegal.
    always_comb begin
        legal  = 1'b0;
        re1    = 1'b0;
        re2    = 1'b0;
        op1    = '0;
        op2    = '0;
        alu    = ALU_ADD;
        word   = 1'b0;

        case (opcode)
            OPC_OP_IMM: begin
                re1   = 1'b1;
                op1   = reg1_rdata;
                op2   = imm_i64[XLEN-1:0];
                legal = 1'b1;
                alu   = base_alu_op(funct3);
                if (funct3 == F3_SLL) begin
                    op2   = shamt64[XLEN-1:0];
                    legal = shift_hi_zero;
                end else if (funct3 == F3_SR) begin
                    op2   = shamt64[XLEN-1:0];
                    legal = shift_hi_zero || shift_hi_sra;
                    alu   = shift_hi_sra ? ALU_SRA : ALU_SRL;
                end
            end
            OPC_OP_IMM_32: begin
                re1  = 1'b1;
                op1  = reg1_rdata;
                word = 1'b1;
                case (funct3)
                    F3_ADD: begin
                        op2   = imm_i64[XLEN-1:0];
                        legal = IS_RV64;
                    end
                    F3_SLL: begin
                        op2   = shamt32[XLEN-1:0];
                        alu   = ALU_SLL;
                        legal = IS_RV64 && (funct7 == F7_BASE);
                    end
                    F3_SR: begin
                        op2   = shamt32[XLEN-1:0];
                        alu   = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = IS_RV64 && ((funct7 == F7_BASE) || (funct7 == F7_ALT));
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP, OPC_OP_32: begin
                re1  = 1'b1;
                re2  = 1'b1;
                op1  = reg1_rdata;
                op2  = reg2_rdata;
                word = (opcode == OPC_OP_32);
                if (funct7 == F7_BASE) begin
                    alu   = base_alu_op(funct3);
                    legal = (opcode == OPC_OP) ||
                            (IS_RV64 && ((funct3 == F3_ADD) || (funct3 == F3_SLL) ||
                                         (funct3 == F3_SR)));
                end else if (funct7 == F7_ALT) begin
                    alu   = (funct3 == F3_SR) ? ALU_SRA : ALU_SUB;
                    legal = ((funct3 == F3_ADD) || (funct3 == F3_SR)) &&
                            ((opcode == OPC_OP) || IS_RV64);
                end
            end
            OPC_LUI: begin
                op2   = imm_u64[XLEN-1:0];
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                op1   = pc;
                op2   = imm_u64[XLEN-1:0];
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            re1  = 1'b0;
            re2  = 1'b0;
            op1  = '0;
            op2  = '0;
            alu  = ALU_ADD;
            word = 1'b0;
        end
    end

    assign reg1_re    = re1;
    assign reg2_re    = re2;
    assign reg1_raddr = re1 ? RADDR_WIDTH'(rs1) : '0;
    assign reg2_raddr = re2 ? RADDR_WIDTH'(rs2) : '0;
    assign alu_op     = ALUOP_WIDTH'(alu);
    assign illegal    = !legal;
    assign reg_we     = legal && (rd != 5'd0);
    assign reg_waddr  = legal ? RADDR_WIDTH'(rd) : '0;

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: valid/ready handshake on both sides, decode via
// id_stage_pipe_decode, one ID/EX register that holds under backpressure.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int RADDR_WIDTH = 5,
    parameter int ALUOP_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [31:0]            inst_i,
    input  logic [XLEN-1:0]        pc_i,
    output logic [RADDR_WIDTH-1:0] reg1_raddr_o,
    output logic [RADDR_WIDTH-1:0] reg2_raddr_o,
    output logic                   reg1_re_o,
    output logic                   reg2_re_o,
    input  logic [XLEN-1:0]        reg1_rdata_i,
    input  logic [XLEN-1:0]        reg2_rdata_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        op1_o,
    output logic [XLEN-1:0]        op2_o,
    output logic [ALUOP_WIDTH-1:0] alu_op_o,
    output logic                   word_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   illegal_o,
    output logic [XLEN-1:0]        pc_o
);

    logic [XLEN-1:0]        dec_op1;
    logic [XLEN-1:0]        dec_op2;
    logic [ALUOP_WIDTH-1:0] dec_alu_op;
    logic                   dec_word;
    logic                   dec_reg_we;
    logic [RADDR_WIDTH-1:0] dec_reg_waddr;
    logic                   dec_illegal;
    logic                   xfer;

    id_stage_pipe_decode #(
        .XLEN        (XLEN),
        .RADDR_WIDTH (RADDR_WIDTH),
        .ALUOP_WIDTH (ALUOP_WIDTH)
    ) u_decode (
        .inst       (inst_i),
        .pc         (pc_i),
        .reg1_rdata (reg1_rdata_i),
        .reg2_rdata (reg2_rdata_i),
        .reg1_raddr (reg1_raddr_o),
        .reg2_raddr (reg2_raddr_o),
        .reg1_re    (reg1_re_o),
        .reg2_re    (reg2_re_o),
        .op1        (dec_op1),
        .op2        (dec_op2),
        .alu_op     (dec_alu_op),
        .word       (dec_word),
        .reg_we     (dec_reg_we),
        .reg_waddr  (dec_reg_waddr),
        .illegal    (dec_illegal)
    );

    assign in_ready_o = !flush_i && (!out_valid_o || out_ready_i);
    assign xfer       = in_valid_i && in_ready_o;

    // Entry valid: flush wins, then load, then drain on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (xfer) begin
            out_valid_o <= 1'b1;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    // Payload only changes on a transfer, so a stalled entry stays bit-stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_o       <= '0;
            op2_o       <= '0;
            alu_op_o    <= '0;
            word_o      <= 1'b0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            illegal_o   <= 1'b0;
            pc_o        <= '0;
        end else if (xfer) begin
            op1_o       <= dec_op1;
            op2_o       <= dec_op2;
            alu_op_o    <= dec_alu_op;
            word_o      <= dec_word;
            reg_we_o    <= dec_reg_we;
            reg_waddr_o <= dec_reg_waddr;
            illegal_o   <= dec_illegal;
            pc_o        <= pc_i;
        end
    end

endmodule
